huffman_resp_packer: RTL and testbench

Receives the byte stream that the Huffman engine emits on its response port (encode or decode output) and packs it little-endian into 64-bit words written back to the scratchpad. It is the write-side counterpart of the scratchpad read path: the engine reads source data through `sp_read_*`, and this block stores its results. The engine cannot be back-pressured, so the block absorbs bursts in a two-word buffer and flags any loss.

---
 rtl/huffman_pkg.sv | 16 +
 rtl/huffman_byte_stage.sv | 90 +++++++++
 rtl/huffman_resp_packer.sv | 172 +++++++++++++++++
 tb/tb_huffman_resp_packer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/huffman_pkg.sv
// huffman_pkg
//   Shared definitions for the Huffman response packer: word geometry and
//   the packer FSM state encoding.
//   Optional feature macro used by the packer files: HUFF_PACK_BYTE_MASK_EN
//   (adds per-byte write enables on the scratchpad write port).
package huffman_pkg;
  localparam int HUFF_WORD_BYTES = 8;
  localparam int HUFF_DATA_W     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } pack_state_t;
endpackage

// File: rtl/huffman_byte_stage.sv
// huffman_byte_stage
//   Little-endian byte assembly stage for the response packer. Collects bytes
//   into lanes of a 64-bit word and hands the word over on 'pop'.
//   Ports:
//     clock, reset   : clock, async active-low reset
//     clr            : clear stage (job start)
//     push, byte_in  : accept one byte into the current lane
//     pop            : stage content leaves this cycle (out_word/out_mask valid)
//     out_word       : word to hand over (includes a completing push byte)
//     out_mask       : byte enables of out_word (HUFF_PACK_BYTE_MASK_EN only)
//     lane, full, empty : stage status
//   Macro: HUFF_PACK_BYTE_MASK_EN adds out_mask.
module huffman_byte_stage
  import huffman_pkg::*;
(
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [7:0]                 byte_in,
  output logic [HUFF_DATA_W-1:0]     out_word,
`ifdef HUFF_PACK_BYTE_MASK_EN
  output logic [HUFF_WORD_BYTES-1:0] out_mask,
`endif
  output logic [2:0]                 lane,
  output logic                       full,
  output logic                       empty
);

  logic [HUFF_DATA_W-1:0] word_q, word_d, merged;
  logic [2:0]             lane_q, lane_d;
  logic                   full_q, full_d;

  always_comb begin
    merged = word_q;
    if (push) merged[{lane_q, 3'b000} +: 8] = byte_in;

    // A held full word leaves as-is; otherwise the word leaves with this
    // cycle's byte merged in (covers the lane-7 completion case).
    out_word = full_q ? word_q : merged;

    word_d = word_q;
    lane_d = lane_q;
    full_d = full_q;
    if (clr) begin
      word_d = '0;
      lane_d = '0;
      full_d = 1'b0;
    end else if (pop) begin
      if (full_q && push) begin
        // Held word leaves while the new byte starts the next word.
        word_d = {{(HUFF_DATA_W-8){1'b0}}, byte_in};
        lane_d = 3'd1;
      end else begin
        word_d = '0;
        lane_d = '0;
      end
      full_d = 1'b0;
    end else if (push) begin
      word_d = merged;
      lane_d = lane_q + 3'd1;
      if (lane_q == 3'd7) full_d = 1'b1;
    end
  end

`ifdef HUFF_PACK_BYTE_MASK_EN
  always_comb begin
    if (full_q || (push && lane_q == 3'd7)) out_mask = '1;
    else                                    out_mask = (8'd1 << lane_q) - 8'd1;
  end
`endif

  assign lane  = lane_q;
  assign full  = full_q;
  assign empty = !full_q && (lane_q == 3'd0);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      lane_q <= '0;
      full_q <= 1'b0;
    end else begin
      word_q <= word_d;
      lane_q <= lane_d;
      full_q <= full_d;
    end
  end

endmodule

// File: rtl/huffman_resp_packer.sv
// huffman_resp_packer
//   Packs the Huffman engine's response byte stream little-endian into 64-bit
//   scratchpad writes. The engine cannot be stalled, so bytes are buffered in
//   a stage word plus one pending word; bytes that do not fit (or exceed the
//   job limit) are dropped and flagged in 'overflow'.
//   Ports:
//     clock, reset              : clock, async active-low reset
//     start_valid/ready         : job request; start_base (word addr), start_limit (bytes)
//     in_valid, in_bits, in_last: engine byte stream and end-of-stream pulse
//     wr_valid/ready, wr_addr, wr_data : scratchpad write handshake
//     wr_mask                   : byte enables (HUFF_PACK_BYTE_MASK_EN only)
//     done                      : one-cycle job completion pulse
//     byte_count, overflow      : bytes stored, sticky loss flag
//   Macro: HUFF_PACK_BYTE_MASK_EN adds wr_mask.
module huffman_resp_packer
  import huffman_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start_valid,
  output logic                       start_ready,
  input  logic [ADDR_W-1:0]          start_base,
  input  logic [CNT_W-1:0]           start_limit,
  input  logic                       in_valid,
  input  logic [7:0]                 in_bits,
  input  logic                       in_last,
  output logic                       wr_valid,
  input  logic                       wr_ready,
  output logic [ADDR_W-1:0]          wr_addr,
  output logic [HUFF_DATA_W-1:0]     wr_data,
`ifdef HUFF_PACK_BYTE_MASK_EN
  output logic [HUFF_WORD_BYTES-1:0] wr_mask,
`endif
  output logic                       done,
  output logic [CNT_W-1:0]           byte_count,
  output logic                       overflow
);

  pack_state_t            state_q, state_d;
  logic                   start_ready_q, start_ready_d;
  logic                   done_q, done_d;
  logic [CNT_W-1:0]       limit_q, limit_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   pend_vld_q, pend_vld_d;
  logic [HUFF_DATA_W-1:0] pend_data_q, pend_data_d;

  logic                   st_clr, st_push, st_pop;
  logic [HUFF_DATA_W-1:0] st_word;
  logic [2:0]             st_lane;
  logic                   st_full, st_empty;
  logic                   wr_fire, can_move, take, cmpl, drop, in_run, in_flush;

`ifdef HUFF_PACK_BYTE_MASK_EN
  logic [HUFF_WORD_BYTES-1:0] st_mask;
  logic [HUFF_WORD_BYTES-1:0] pend_mask_q, pend_mask_d;
`endif

  huffman_byte_stage u_stage (
    .clock    (clock),
    .reset    (reset),
    .clr      (st_clr),
    .push     (st_push),
    .pop      (st_pop),
    .byte_in  (in_bits),
    .out_word (st_word),
`ifdef HUFF_PACK_BYTE_MASK_EN
    .out_mask (st_mask),
`endif
    .lane     (st_lane),
    .full     (st_full),
    .empty    (st_empty)
  );

  always_comb begin
    in_run   = (state_q == RUN);
    in_flush = (state_q == FLUSH);
    wr_fire  = pend_vld_q && wr_ready;
    // Pending can take a word if it is empty or is being written this cycle.
    can_move = !pend_vld_q || wr_ready;

    st_clr  = (state_q == IDLE) && start_valid;
    take    = in_run && in_valid;
    st_push = take && (count_q != limit_q) && (!st_full || can_move);
    drop    = take && !st_push;
    cmpl    = st_push && !st_full && (st_lane == 3'd7);
    st_pop  = can_move && ((in_run && (st_full || cmpl)) || (in_flush && !st_empty));

    state_d = state_q;
    case (state_q)
      IDLE:    if (start_valid) state_d = RUN;
      RUN:     if (in_last) state_d = FLUSH;
      FLUSH:   if (st_empty && !pend_vld_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    start_ready_d = (state_d == IDLE);
    done_d        = (state_d == DONE);

    limit_d = st_clr ? start_limit : limit_q;
    count_d = count_q;
    if (st_clr)       count_d = '0;
    else if (st_push) count_d = count_q + CNT_W'(1);
    ovf_d = ovf_q;
    if (st_clr)    ovf_d = 1'b0;
    else if (drop) ovf_d = 1'b1;
    addr_d = addr_q;
    if (st_clr)       addr_d = start_base;
    else if (wr_fire) addr_d = addr_q + ADDR_W'(1);

    pend_vld_d  = pend_vld_q;
    pend_data_d = pend_data_q;
`ifdef HUFF_PACK_BYTE_MASK_EN
    pend_mask_d = pend_mask_q;
`endif
    if (st_pop) begin
      pend_vld_d  = 1'b1;
      pend_data_d = st_word;
`ifdef HUFF_PACK_BYTE_MASK_EN
      pend_mask_d = st_mask;
`endif
    end else if (wr_fire) begin
      pend_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      start_ready_q <= 1'b1;
      done_q        <= 1'b0;
      limit_q       <= '0;
      count_q       <= '0;
      ovf_q         <= 1'b0;
      addr_q        <= '0;
      pend_vld_q    <= 1'b0;
      pend_data_q   <= '0;
`ifdef HUFF_PACK_BYTE_MASK_EN
      pend_mask_q   <= '0;
`endif
    end else begin
      state_q       <= state_d;
      start_ready_q <= start_ready_d;
      done_q        <= done_d;
      limit_q       <= limit_d;
      count_q       <= count_d;
      ovf_q         <= ovf_d;
      addr_q        <= addr_d;
      pend_vld_q    <= pend_vld_d;
      pend_data_q   <= pend_data_d;
`ifdef HUFF_PACK_BYTE_MASK_EN
      pend_mask_q   <= pend_mask_d;
`endif
    end
  end

  assign start_ready = start_ready_q;
  assign done        = done_q;
  assign byte_count  = count_q;
  assign overflow    = ovf_q;
  assign wr_valid    = pend_vld_q;
  assign wr_addr     = addr_q;
  assign wr_data     = pend_data_q;
`ifdef HUFF_PACK_BYTE_MASK_EN
  assign wr_mask     = pend_mask_q;
`endif

endmodule

// File: tb/tb_huffman_resp_packer.sv
// tb_huffman_resp_packer
//   Scoreboard bench for huffman_resp_packer: a byte-level model pushes the
//   expected scratchpad writes as bytes are driven; a negedge monitor pops and
//   compares each write the DUT issues.
module tb_huffman_resp_packer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] start_base = '0;
  logic [31:0] start_limit = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_bits = '0;
  logic        in_last = 1'b0;
  logic        wr_valid;
  logic        wr_ready = 1'b0;
  logic [15:0] wr_addr;
  logic [63:0] wr_data;
`ifdef HUFF_PACK_BYTE_MASK_EN
  logic [7:0]  wr_mask;
`endif
  logic        done;
  logic [31:0] byte_count;
  logic        overflow;

  huffman_resp_packer #(.ADDR_W(16), .CNT_W(32)) dut (
    .clock       (clock),
    .reset       (reset),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .start_base  (start_base),
    .start_limit (start_limit),
    .in_valid    (in_valid),
    .in_bits     (in_bits),
    .in_last     (in_last),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
`ifdef HUFF_PACK_BYTE_MASK_EN
    .wr_mask     (wr_mask),
`endif
    .done        (done),
    .byte_count  (byte_count),
    .overflow    (overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    logic [63:0] data;
    logic [7:0]  mask;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  wr_cnt = 0;

  // model state
  logic [63:0] m_word;
  logic [15:0] m_addr;
  int          m_lane, m_cnt, m_limit, m_held;
  bit          m_ovf, hold;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] mask);
    exp_q.push_back('{m_addr, m_word, mask});
    m_addr = m_addr + 16'd1;
    m_word = '0;
    m_lane = 0;
  endtask

  task automatic check_reset_vals();
    check("rst_start_ready", start_ready, 1);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    check("rst_byte_count", byte_count, 0);
    check("rst_overflow", overflow, 0);
`ifdef HUFF_PACK_BYTE_MASK_EN
    check("rst_wr_mask", wr_mask, 0);
`endif
  endtask

  task automatic start_job(input logic [15:0] base, input int lim);
    check("start_ready", start_ready, 1);
    m_addr = base; m_limit = lim; m_cnt = 0; m_ovf = 0;
    m_lane = 0; m_word = '0; m_held = 0; wr_cnt = 0;
    start_base = base; start_limit = lim; start_valid = 1'b1;
    @(posedge clock); #1;
    start_valid = 1'b0;
  endtask

  // Model: job limit first, then (while writes are stalled) two buffered words.
  task automatic send_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_bits  = b;
    if (m_cnt == m_limit || (hold && m_held == 2)) begin
      m_ovf = 1;
    end else begin
      m_word[8*m_lane +: 8] = b;
      m_lane++;
      m_cnt++;
      if (m_lane == 8) begin
        push_exp(8'hFF);
        if (hold) m_held++;
      end
    end
    @(posedge clock); #1;
  endtask

  task automatic finish_job(input bit check_lat);
    int n;
    bit seen;
    in_valid = 1'b0;
    if (m_lane > 0) push_exp(8'((1 << m_lane) - 1));
    in_last = 1'b1;
    @(posedge clock); #1;
    in_last = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      @(negedge clock);
      n++;
      if (done) seen = 1;
    end
    check("done_seen", seen, 1);
    if (check_lat) check("done_latency", n, 2);
    check("byte_count", byte_count, m_cnt);
    check("overflow", overflow, m_ovf);
    check("writes_outstanding", exp_q.size(), 0);
    @(negedge clock);
    check("done_one_cycle", done, 0);
    @(posedge clock); #1;
  endtask

  // write monitor / scoreboard
  wr_t         mon_e;
  bit          stall_prev = 0;
  logic [15:0] prev_addr;
  logic [63:0] prev_data;
  always @(negedge clock) begin
    if (reset) begin
      if (stall_prev && wr_valid) begin
        check("stall_addr", wr_addr, prev_addr);
        check("stall_data", wr_data, prev_data);
      end
      if (wr_valid && wr_ready) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", wr_addr, mon_e.addr);
          check("wr_data", wr_data, mon_e.data);
`ifdef HUFF_PACK_BYTE_MASK_EN
          check("wr_mask", wr_mask, mon_e.mask);
`endif
        end
      end
      stall_prev = wr_valid && !wr_ready;
      prev_addr  = wr_addr;
      prev_data  = wr_data;
    end else begin
      stall_prev = 0;
      if (wr_valid) check("wr_valid_in_reset", wr_valid, 0);
    end
  end

  initial begin
    hold = 0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals();
    reset = 1'b1;
    @(posedge clock); #1;

    // 16 bytes, two full words
    wr_ready = 1'b1;
    start_job(16'h0040, 1000);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    finish_job(0);
    check("t1_writes", wr_cnt, 2);

    // partial word
    start_job(16'h0010, 1000);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    finish_job(0);
    check("t2_writes", wr_cnt, 1);

    // stalled writes: 24 bytes, only 16 fit
    wr_ready = 1'b0;
    hold = 1;
    start_job(16'h0080, 1000);
    for (int i = 0; i < 24; i++) send_byte(8'(i + 1));
    in_valid = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("t3_no_wr_stalled", wr_cnt, 0);
    check("t3_wr_valid_held", wr_valid, 1);
    check("t3_overflow_early", overflow, 1);
    wr_ready = 1'b1;
    hold = 0;
    m_held = 0;
    repeat (4) @(posedge clock);
    #1;
    finish_job(0);
    check("t3_writes", wr_cnt, 2);

    // byte limit
    start_job(16'h0020, 5);
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    finish_job(0);
    check("t4_writes", wr_cnt, 1);

    // empty job
    start_job(16'h0030, 1000);
    finish_job(1);
    check("t5_writes", wr_cnt, 0);

    // reset mid-job
    start_job(16'h0050, 1000);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_reset_vals();
    m_lane = 0; m_word = '0;
    repeat (3) @(posedge clock);
    #1;
    check_reset_vals();
    reset = 1'b1;
    @(posedge clock); #1;
    check("t6_no_write", wr_cnt, 0);

    // new job after reset, address wrap at the top of the space
    start_job(16'hFFFF, 1000);
    for (int i = 0; i < 16; i++) send_byte(8'(8'hF0 ^ i));
    finish_job(0);
    check("t6_writes", wr_cnt, 2);
    check("t6_wrap_addr", wr_addr, 16'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
